config_register_bank: RTL and testbench
=======================================

Name: config_register_bank

Overview:
- Parametrised, password-gated configuration register bank.
- Generalises the fixed two-register P/Q configuration unit to NUM_REGS registers of DATA_WIDTH bits.
- Adds a registered FSM with abort on request, a failed-attempt counter and a timed lockout.
- Sits between the debounced front-panel controls (request/confirm pulses, key switches) and datapath blocks that consume configuration words.

Parameters:
- DATA_WIDTH, 7: width of each configuration register.
- NUM_REGS, 2: number of configuration registers; must be >= 1.
- KEY_WIDTH, 8: width of password and user_data; must be >= DATA_WIDTH.
- MAX_TRIES, 3: consecutive failed authentications that trigger lockout; must be >= 1.
- LOCK_CYCLES, 1024: lockout duration in clock cycles; must be >= 1.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- request  in  1  single-cycle pulse: start a session (IDLE) or abort (WRITE).
- confirm  in  1  single-cycle pulse: submit user_data.
- password  in  KEY_WIDTH  reference password (key switches).
- user_data  in  KEY_WIDTH  password attempt or configuration word.
- reg_data  out  NUM_REGS*DATA_WIDTH  register i at [i*DATA_WIDTH +: DATA_WIDTH].
- write_index  out  IDX_W = max(1, clog2(NUM_REGS))  next register to be written.
- busy  out  1  high in AUTH or WRITE.
- locked  out  1  high in LOCKED.
- done  out  1  one-cycle pulse when the last register has been written.
- auth_fail  out  1  one-cycle pulse on a wrong password.

Behaviour:
- Only one clock domain: clock. reset is synchronous and active-high.
- Reset, including mid-session or mid-lockout: state = IDLE; all registers, write_index, fail_cnt and lock_cnt = 0; busy, locked, done and auth_fail = 0.
- All outputs are registered. An effect is visible the cycle after the input pulse is sampled.
- IDLE:
  - request -> AUTH.
  - confirm is ignored.
- AUTH:
  - confirm with user_data == password -> WRITE; write_index = 0; fail_cnt = 0.
  - confirm with mismatch -> pulse auth_fail; fail_cnt++.
    - If the new fail_cnt == MAX_TRIES: go to LOCKED with lock_cnt = LOCK_CYCLES-1.
    - Otherwise: go to IDLE.
  - request alone: ignored. If request and confirm arrive together, confirm wins.
- WRITE:
  - confirm -> reg[write_index] <= user_data[DATA_WIDTH-1:0].
    - If write_index == NUM_REGS-1: go to IDLE, pulse done, write_index = 0.
    - Otherwise: write_index++.
  - request -> abort to IDLE, write_index = 0. Already-written registers keep their new values; unwritten registers keep their old values.
  - request and confirm together: request wins; no write occurs.
- LOCKED:
  - request and confirm are ignored.
  - lock_cnt decrements every cycle. At 0 -> IDLE with fail_cnt = 0. LOCKED lasts exactly LOCK_CYCLES cycles.
- fail_cnt is cleared only by a successful authentication, lockout expiry or reset. Failures separated by IDLE periods accumulate.
- Password comparison is over the full KEY_WIDTH. Data writes truncate user_data to its low DATA_WIDTH bits.
- NUM_REGS = 1: write_index is a constant 0; the first confirm in WRITE ends the session.
- Registers are updated only by WRITE-state confirms; reg_data is stable otherwise.

Decomposition:
- Shared package config_pkg:
  - state enum {IDLE, AUTH, WRITE, LOCKED}.
  - Index-width function max(1, clog2(n)).
- Sub-module config_word_reg: DATA_WIDTH register with synchronous reset and write enable, instantiated NUM_REGS times via generate.
- The FSM, fail counter and lock counter live in the top module.

Test Plan (DATA_WIDTH=7, NUM_REGS=3, KEY_WIDTH=8, MAX_TRIES=3, LOCK_CYCLES=16, password=8'hA5):
- Nominal session: request; confirm 8'hA5; confirm 8'h11, 8'h22, 8'hFF -> reg_data = {7'h7F, 7'h22, 7'h11}; done pulses once, in the cycle after the third confirm; busy falls the same cycle.
- Wrong password: request; confirm 8'h5A -> auth_fail pulses once; state IDLE; reg_data unchanged at 0.
- Lockout: three request/confirm 8'h00 sequences -> locked rises after the third; request/confirm 8'hA5 during lockout ignored; locked high exactly 16 cycles; a subsequent correct session succeeds.
- Abort: authenticate; write 8'h33; then request and confirm 8'h44 in the same cycle -> reg0 = 7'h33, reg1 and reg2 unchanged; IDLE; write_index = 0; no done pulse.
- Fail-counter clearing: two failures, then a successful session, then two failures -> locked never asserts.
- Reset mid-WRITE (after one write) and mid-LOCKED -> all registers 0, IDLE, locked = 0, the next cycle accepts request.

Source files
------------

// File: rtl/config_pkg.sv
// Shared types and helpers for the password-gated configuration register bank.
package config_pkg;

    typedef enum logic [1:0] {
        IDLE,
        AUTH,
        WRITE,
        LOCKED
    } state_t;

    // Width of an index or counter able to hold 0..n-1, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/config_word_reg.sv
// One configuration word: a DATA_WIDTH register with synchronous reset and write enable.
module config_word_reg #(
    parameter int DATA_WIDTH = 7
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  write_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out
);

    // NOTE: configuration words are flops, not a RAM, so they take the reset like any other state.
    always_ff @(posedge clock) begin
        if (reset) begin
            data_out <= '0;
        end else if (write_en) begin
            data_out <= data_in;
        end
    end

endmodule

// File: rtl/config_register_bank.sv
// Password-gated bank of NUM_REGS configuration words with failed-attempt lockout.
module config_register_bank
    import config_pkg::*;
#(
    parameter  int DATA_WIDTH  = 7,
    parameter  int NUM_REGS    = 2,
    parameter  int KEY_WIDTH   = 8,
    parameter  int MAX_TRIES   = 3,
    parameter  int LOCK_CYCLES = 1024,
    localparam int IDX_W       = idx_width(NUM_REGS)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         request,
    input  logic                         confirm,
    input  logic [KEY_WIDTH-1:0]         password,
    input  logic [KEY_WIDTH-1:0]         user_data,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_data,
    output logic [IDX_W-1:0]             write_index,
    output logic                         busy,
    output logic                         locked,
    output logic                         done,
    output logic                         auth_fail
);

    localparam int FAIL_W = idx_width(MAX_TRIES + 1);
    localparam int LOCK_W = idx_width(LOCK_CYCLES);

    state_t            state, next_state;
    logic [IDX_W-1:0]  next_index;
    logic [FAIL_W-1:0] fail_cnt, next_fail;
    logic [LOCK_W-1:0] lock_cnt, next_lock;
    logic              next_done, next_auth_fail;
    logic              write_en;

    // NOTE: sequential state uses <= so every flop samples pre-edge values; the comb block uses =.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            write_index <= '0;
            fail_cnt    <= '0;
            lock_cnt    <= '0;
            busy        <= 1'b0;
            locked      <= 1'b0;
            done        <= 1'b0;
            auth_fail   <= 1'b0;
        end else begin
            state       <= next_state;
            write_index <= next_index;
            fail_cnt    <= next_fail;
            lock_cnt    <= next_lock;
            busy        <= (next_state == AUTH) || (next_state == WRITE);
            locked      <= (next_state == LOCKED);
            done        <= next_done;
            auth_fail   <= next_auth_fail;
        end
    end

    // NOTE: every variable gets a default up front so no path through the case infers a latch.
    always_comb begin
        next_state     = state;
        next_index     = write_index;
        next_fail      = fail_cnt;
        next_lock      = lock_cnt;
        next_done      = 1'b0;
        next_auth_fail = 1'b0;
        write_en       = 1'b0;
        case (state)
            IDLE: begin
                if (request) next_state = AUTH;
            end
            AUTH: begin
                if (confirm) begin
                    if (user_data == password) begin
                        next_state = WRITE;
                        next_index = '0;
                        next_fail  = '0;
                    end else begin
                        next_auth_fail = 1'b1;
                        next_fail      = fail_cnt + FAIL_W'(1);
                        if (fail_cnt == FAIL_W'(MAX_TRIES - 1)) begin
                            next_state = LOCKED;
                            next_lock  = LOCK_W'(LOCK_CYCLES - 1);
                        end else begin
                            next_state = IDLE;
                        end
                    end
                end
            end
            WRITE: begin
                // Abort takes priority over a simultaneous write.
                if (request) begin
                    next_state = IDLE;
                    next_index = '0;
                end else if (confirm) begin
                    write_en = 1'b1;
                    if (write_index == IDX_W'(NUM_REGS - 1)) begin
                        next_state = IDLE;
                        next_done  = 1'b1;
                        next_index = '0;
                    end else begin
                        next_index = write_index + IDX_W'(1);
                    end
                end
            end
            LOCKED: begin
                if (lock_cnt == '0) begin
                    next_state = IDLE;
                    next_fail  = '0;
                end else begin
                    next_lock = lock_cnt - LOCK_W'(1);
                end
            end
            default: next_state = IDLE;
        endcase
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_word
        config_word_reg #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_word (
            .clock    (clock),
            .reset    (reset),
            .write_en (write_en && (write_index == IDX_W'(i))),
            .data_in  (user_data[DATA_WIDTH-1:0]),
            .data_out (reg_data[i*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_config_register_bank.sv
// Scoreboard bench: stimulus queues expected done/auth_fail/lock events, a monitor pops and compares them.
module tb_config_register_bank;

    localparam int DW = 7;
    localparam int NR = 3;
    localparam int KW = 8;
    localparam int MT = 3;
    localparam int LC = 16;
    localparam logic [KW-1:0] PASSWORD = 8'hA5;

    typedef enum int {EV_DONE, EV_FAIL, EV_LOCK_ON, EV_LOCK_OFF} ev_kind_t;
    typedef struct {
        ev_kind_t         kind;
        logic [NR*DW-1:0] regs;
        int               len;
    } exp_t;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              request = 1'b0;
    logic              confirm = 1'b0;
    logic [KW-1:0]     password = PASSWORD;
    logic [KW-1:0]     user_data = '0;
    logic [NR*DW-1:0]  reg_data;
    logic [1:0]        write_index;
    logic              busy, locked, done, auth_fail;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    config_register_bank #(
        .DATA_WIDTH(DW), .NUM_REGS(NR), .KEY_WIDTH(KW), .MAX_TRIES(MT), .LOCK_CYCLES(LC)
    ) dut (
        .clock(clock), .reset(reset), .request(request), .confirm(confirm),
        .password(password), .user_data(user_data), .reg_data(reg_data),
        .write_index(write_index), .busy(busy), .locked(locked), .done(done),
        .auth_fail(auth_fail)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic expect_ev(input ev_kind_t kind, input logic [NR*DW-1:0] regs, input int len);
        exp_t e;
        e.kind = kind;
        e.regs = regs;
        e.len  = len;
        exp_q.push_back(e);
    endtask

    // One cycle of input, sampled at the next rising edge; returns 1 time unit after that edge.
    task automatic pulse(input logic req, input logic conf, input logic [KW-1:0] data);
        request   = req;
        confirm   = conf;
        user_data = data;
        @(posedge clock); #1;
        request   = 1'b0;
        confirm   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clock); #1;
        end
    endtask

    // Monitor: compares every output event against the head of the scoreboard queue.
    logic locked_prev = 1'b0;
    int   lock_len = 0;

    task automatic pop_cmp(input ev_kind_t kind, input int len);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event: got kind %0d, expected none", kind);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", kind, e.kind);
            if (kind == EV_DONE || kind == EV_FAIL) check("event_reg_data", reg_data, e.regs);
            if (kind == EV_LOCK_OFF && e.len >= 0) check("lock_length", len, e.len);
        end
    endtask

    initial begin
        forever begin
            @(negedge clock);
            if (auth_fail) pop_cmp(EV_FAIL, 0);
            if (done) pop_cmp(EV_DONE, 0);
            if (locked && !locked_prev) begin
                pop_cmp(EV_LOCK_ON, 0);
                lock_len = 0;
            end
            if (locked) lock_len++;
            if (!locked && locked_prev) pop_cmp(EV_LOCK_OFF, lock_len);
            locked_prev = locked;
        end
    end

    initial begin
        int waited;
        @(posedge clock); #1;
        do_reset();
        check("reset_reg_data", reg_data, 0);
        check("reset_busy", busy, 0);
        check("reset_locked", locked, 0);
        check("reset_index", write_index, 0);

        // Wrong password straight after reset.
        expect_ev(EV_FAIL, '0, 0);
        pulse(1, 0, 8'h00);
        check("auth_busy", busy, 1);
        pulse(0, 1, 8'h5A);
        check("wrong_pw_idle", busy, 0);
        check("wrong_pw_regs", reg_data, 0);

        // Nominal session; 8'hFF truncates to 7'h7F.
        pulse(1, 0, 8'h00);
        pulse(0, 1, PASSWORD);
        check("write_busy", busy, 1);
        pulse(0, 1, 8'h11);
        pulse(0, 1, 8'h22);
        check("index_before_last", write_index, 2);
        expect_ev(EV_DONE, {7'h7F, 7'h22, 7'h11}, 0);
        pulse(0, 1, 8'hFF);
        check("busy_falls_with_done", busy, 0);
        check("nominal_regs", reg_data, {7'h7F, 7'h22, 7'h11});
        check("index_after_done", write_index, 0);

        // Lockout after three consecutive failures; attempts during lockout are ignored.
        for (int i = 0; i < MT; i++) begin
            expect_ev(EV_FAIL, {7'h7F, 7'h22, 7'h11}, 0);
            if (i == MT - 1) begin
                expect_ev(EV_LOCK_ON, '0, 0);
                expect_ev(EV_LOCK_OFF, '0, LC);
            end
            pulse(1, 0, 8'h00);
            pulse(0, 1, 8'h00);
        end
        check("locked_rises", locked, 1);
        pulse(1, 0, 8'h00);
        pulse(0, 1, PASSWORD);
        check("locked_ignores_busy", busy, 0);
        waited = 0;
        while (locked && waited < 40) begin
            idle_cycles(1);
            waited++;
        end
        check("lock_expired_in_time", locked, 0);
        expect_ev(EV_DONE, {7'h03, 7'h02, 7'h01}, 0);
        pulse(1, 0, 8'h00);
        pulse(0, 1, PASSWORD);
        pulse(0, 1, 8'h01);
        pulse(0, 1, 8'h02);
        pulse(0, 1, 8'h03);
        check("post_lock_regs", reg_data, {7'h03, 7'h02, 7'h01});

        // Abort with simultaneous request+confirm: request wins, no write.
        pulse(1, 0, 8'h00);
        pulse(0, 1, PASSWORD);
        pulse(0, 1, 8'h33);
        pulse(1, 1, 8'h44);
        check("abort_regs", reg_data, {7'h03, 7'h02, 7'h33});
        check("abort_idle", busy, 0);
        check("abort_index", write_index, 0);

        // Two failures, a success, two failures: never locks.
        for (int i = 0; i < 2; i++) begin
            expect_ev(EV_FAIL, {7'h03, 7'h02, 7'h33}, 0);
            pulse(1, 0, 8'h00);
            pulse(0, 1, 8'h5A);
        end
        expect_ev(EV_DONE, {7'h03, 7'h02, 7'h01}, 0);
        pulse(1, 0, 8'h00);
        pulse(0, 1, PASSWORD);
        pulse(0, 1, 8'h81);
        pulse(0, 1, 8'h82);
        pulse(0, 1, 8'h83);
        for (int i = 0; i < 2; i++) begin
            expect_ev(EV_FAIL, {7'h03, 7'h02, 7'h01}, 0);
            pulse(1, 0, 8'h00);
            pulse(0, 1, 8'h5A);
        end
        check("fail_cnt_cleared_no_lock", locked, 0);

        // Reset mid-WRITE.
        pulse(1, 0, 8'h00);
        pulse(0, 1, PASSWORD);
        pulse(0, 1, 8'h55);
        do_reset();
        check("rst_write_regs", reg_data, 0);
        check("rst_write_busy", busy, 0);
        check("rst_write_index", write_index, 0);
        pulse(1, 0, 8'h00);
        check("rst_write_accepts_request", busy, 1);
        pulse(0, 1, PASSWORD);
        pulse(1, 0, 8'h00);

        // Reset mid-LOCKED.
        for (int i = 0; i < MT; i++) begin
            expect_ev(EV_FAIL, '0, 0);
            if (i == MT - 1) begin
                expect_ev(EV_LOCK_ON, '0, 0);
                expect_ev(EV_LOCK_OFF, '0, -1);
            end
            pulse(1, 0, 8'h00);
            pulse(0, 1, 8'h00);
        end
        idle_cycles(5);
        check("pre_reset_locked", locked, 1);
        do_reset();
        check("rst_lock_locked", locked, 0);
        check("rst_lock_regs", reg_data, 0);
        pulse(1, 0, 8'h00);
        check("rst_lock_accepts_request", busy, 1);
        pulse(0, 1, PASSWORD);
        pulse(1, 0, 8'h00);

        idle_cycles(3);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
